// File: rtl/seq_pkg.sv
`timescale 1ns/1ps
// seq_pkg
// Shared definitions for the instruction sequencer:
//   state_e        - controller state enumeration (3-bit encoding)
//   SC_*           - state_control codes driven by the instruction decoder
//   DEFAULT_LAST_OPCODE - highest legal opcode unless overridden
//   CNT_W          - width of the memory-read wait counter
//   sat_inc16      - saturating increment used by the retire counter
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LOAD_IR   = 3'd2,
    ST_EXEC      = 3'd3,
    ST_MEM_WAIT  = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

  localparam logic [1:0] SC_EXEC = 2'b00;
  localparam logic [1:0] SC_MRD  = 2'b01;
  localparam logic [1:0] SC_MWR  = 2'b10;
  localparam logic [1:0] SC_HALT = 2'b11;

  localparam logic [7:0] DEFAULT_LAST_OPCODE = 8'h1f;

  // Wide enough for a memory latency of up to 15 cycles.
  localparam int CNT_W = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wait_counter.sv
`timescale 1ns/1ps
// wait_counter
// Load/decrement down-counter that times the memory-read wait.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   load      - capture load_val (has priority over dec)
//   load_val  - value loaded; number of extra wait cycles after the first
//   dec       - decrement by one, holding at zero
//   done      - count is zero
module wait_counter
  import seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
// instr_sequencer
// Fetch/execute controller for the 8-bit datapath. Fetches an opcode from
// the instruction ROM into the instruction register, lets the decoder
// classify it through state_control, and issues exactly one datapath strobe
// in the cycles where architectural state is allowed to change.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   start          - pulse; leaves IDLE (ignored while busy or halted)
//   step_mode      - 1: return to IDLE after each retired instruction
//   imem_data      - ROM data, valid the cycle after imem_rd
//   state_control  - decoder class: exec / mem read / mem write / halt
//   imem_addr, imem_rd - ROM address (= pc) and read strobe
//   opcode         - instruction register, feeds the decoder
//   reg_we, mem_rd, mem_we - datapath strobes
//   pc             - program counter
//   busy, halted, illegal - status; illegal is sticky until reset
//   retired        - saturating count of retired instructions
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int         PC_W        = 8,
  parameter int         MEM_LAT     = 2,
  parameter logic [7:0] LAST_OPCODE = DEFAULT_LAST_OPCODE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step_mode,
  input  logic [7:0]      imem_data,
  input  logic [1:0]      state_control,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  output logic [7:0]      opcode,
  output logic            reg_we,
  output logic            mem_rd,
  output logic            mem_we,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic [15:0]     retired
);

  // The counter is loaded in EXEC; MEM_WAIT then runs until it reads zero,
  // giving exactly MEM_LAT wait cycles.
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_LAT - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [15:0]     retired_q, retired_d;
  logic            illegal_q, illegal_d;

  logic imem_rd_c, reg_we_c, mem_rd_c, mem_we_c;
  logic wc_load, wc_dec, wc_done;
  logic retire;
  logic opcode_illegal;

  assign opcode_illegal = (opcode_q > LAST_OPCODE);

  wait_counter #(
    .W(CNT_W)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (wc_load),
    .load_val (WAIT_INIT),
    .dec      (wc_dec),
    .done     (wc_done)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    imem_rd_c = 1'b0;
    reg_we_c  = 1'b0;
    mem_rd_c  = 1'b0;
    mem_we_c  = 1'b0;
    wc_load   = 1'b0;
    wc_dec    = 1'b0;
    retire    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        imem_rd_c = 1'b1;
        state_d   = ST_LOAD_IR;
      end
      ST_LOAD_IR: begin
        opcode_d = imem_data;
        pc_d     = pc_q + PC_W'(1);
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        // An out-of-range opcode halts regardless of what the decoder says.
        if (opcode_illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          case (state_control)
            SC_EXEC: begin
              reg_we_c = 1'b1;
              retire   = 1'b1;
            end
            SC_MRD: begin
              mem_rd_c = 1'b1;
              wc_load  = 1'b1;
              state_d  = ST_MEM_WAIT;
            end
            SC_MWR: begin
              mem_we_c = 1'b1;
              retire   = 1'b1;
            end
            default: begin
              state_d = ST_HALT;
            end
          endcase
        end
      end
      ST_MEM_WAIT: begin
        mem_rd_c = 1'b1;
        if (wc_done) begin
          state_d = ST_WRITEBACK;
        end else begin
          wc_dec = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        reg_we_c = 1'b1;
        retire   = 1'b1;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (retire) begin
      retired_d = sat_inc16(retired_q);
      state_d   = step_mode ? ST_IDLE : ST_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      opcode_q  <= 8'h00;
      retired_q <= 16'h0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes are suppressed while rst is high so a reset that lands in the
  // middle of an instruction cannot disturb the datapath in that cycle.
  assign imem_rd   = imem_rd_c & ~rst;
  assign reg_we    = reg_we_c  & ~rst;
  assign mem_rd    = mem_rd_c  & ~rst;
  assign mem_we    = mem_we_c  & ~rst;

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign opcode    = opcode_q;
  assign retired   = retired_q;
  assign illegal   = illegal_q;
  assign halted    = (state_q == ST_HALT);
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
`timescale 1ns/1ps
// Testbench for instr_sequencer: instruction-level reference model that
// expands each fetched instruction into its expected per-cycle strobe plan,
// compared against the DUT every cycle, plus directed literal checks.
module tb_instr_sequencer;

  localparam int         PC_W    = 8;
  localparam int         MEM_LAT = 2;
  localparam logic [7:0] LAST_OP = 8'h1f;

  logic            clk = 1'b0;
  logic            rst, start, step_mode;
  logic [7:0]      imem_data;
  logic [1:0]      state_control;
  logic [PC_W-1:0] imem_addr, pc;
  logic            imem_rd, reg_we, mem_rd, mem_we, busy, halted, illegal;
  logic [7:0]      opcode;
  logic [15:0]     retired;

  int checks = 0;
  int errors = 0;

  instr_sequencer #(
    .PC_W(PC_W), .MEM_LAT(MEM_LAT), .LAST_OPCODE(LAST_OP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode),
    .imem_data(imem_data), .state_control(state_control),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .opcode(opcode),
    .reg_we(reg_we), .mem_rd(mem_rd), .mem_we(mem_we), .pc(pc),
    .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  // Instruction ROM (registered read) and a table-driven decoder.
  logic [7:0] rom [256];
  logic [1:0] sc_tab [256];
  always @(posedge clk) if (imem_rd) imem_data <= rom[imem_addr];
  assign state_control = sc_tab[opcode];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam logic [2:0] S_NONE = 3'd0, S_IMEM = 3'd1, S_REG = 3'd2, S_MRD = 3'd3, S_MWE = 3'd4;
  localparam logic [2:0] E_NONE = 3'd0, E_LOAD = 3'd1, E_RETIRE = 3'd2, E_HALT = 3'd3, E_ILL = 3'd4;
  typedef struct packed { logic [2:0] s; logic [2:0] e; } step_t;

  step_t      plan [$];
  logic [7:0] m_pc;
  logic [7:0] m_op;
  int         m_ret;
  bit         m_ill, m_halt;

  // Expand the instruction at m_pc into the cycles it will occupy.
  task automatic build_plan();
    logic [7:0] op;
    op = rom[m_pc];
    plan.push_back({S_IMEM, E_NONE});
    plan.push_back({S_NONE, E_LOAD});
    if (op > LAST_OP) begin
      plan.push_back({S_NONE, E_ILL});
    end else begin
      case (sc_tab[op])
        2'b00: plan.push_back({S_REG, E_RETIRE});
        2'b01: begin
          plan.push_back({S_MRD, E_NONE});
          for (int k = 0; k < MEM_LAT; k++) plan.push_back({S_MRD, E_NONE});
          plan.push_back({S_REG, E_RETIRE});
        end
        2'b10: plan.push_back({S_MWE, E_RETIRE});
        default: plan.push_back({S_NONE, E_HALT});
      endcase
    end
  endtask

  always @(posedge clk) begin
    step_t cur;
    if (rst) begin
      plan.delete();
      m_pc = 8'h00; m_op = 8'h00; m_ret = 0; m_ill = 0; m_halt = 0;
    end else if (plan.size() != 0) begin
      cur = plan.pop_front();
      case (cur.e)
        E_LOAD: begin m_op = rom[m_pc]; m_pc = m_pc + 8'd1; end
        E_RETIRE: begin
          if (m_ret < 65535) m_ret++;
          if (!step_mode) build_plan();
        end
        E_HALT: m_halt = 1;
        E_ILL: begin m_halt = 1; m_ill = 1; end
        default: ;
      endcase
    end else if (!m_halt && start) begin
      build_plan();
    end
  end

  always @(negedge clk) begin
    step_t h;
    logic [2:0] es;
    es = S_NONE;
    if (!rst && plan.size() != 0) begin h = plan[0]; es = h.s; end
    chk("imem_rd", imem_rd, es == S_IMEM);
    chk("reg_we",  reg_we,  es == S_REG);
    chk("mem_rd",  mem_rd,  es == S_MRD);
    chk("mem_we",  mem_we,  es == S_MWE);
    chk("pc",        pc,        m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("opcode",    opcode,    m_op);
    chk("retired",   retired,   m_ret);
    chk("busy",      busy,      plan.size() != 0);
    chk("halted",    halted,    m_halt);
    chk("illegal",   illegal,   m_ill);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 256; i++) begin rom[i] = 8'h00; sc_tab[i] = 2'b00; end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    do begin tick(); @(negedge clk); n++; end while (busy && n < budget);
    chk({tag, "_idle_timeout"}, busy, 0);
  endtask

  initial begin
    int mrd_cnt, mrd_first, mrd_last, rwe_cnt, rwe_at, bsy_cnt, wr_cnt, n, r;
    rst = 1'b1; start = 1'b0; step_mode = 1'b0;
    clear_tables();

    // --- T1: single exec instruction, step mode, reset state ---
    rom[0] = 8'h03; rom[1] = 8'h05; step_mode = 1'b1;
    tick(); tick(); rst = 1'b0;
    @(negedge clk);
    chk("t0_rst_pc", pc, 0);       chk("t0_rst_opcode", opcode, 0);
    chk("t0_rst_retired", retired, 0); chk("t0_rst_busy", busy, 0);
    chk("t0_rst_halted", halted, 0);   chk("t0_rst_illegal", illegal, 0);
    tick();
    pulse_start();                                   // cycle 1
    @(negedge clk); chk("t1_imem_rd_c1", imem_rd, 1);
    tick(); tick();                                  // cycle 3
    @(negedge clk);
    chk("t1_opcode_c3", opcode, 8'h03); chk("t1_reg_we_c3", reg_we, 1); chk("t1_pc_c3", pc, 1);
    tick();                                          // cycle 4
    @(negedge clk);
    chk("t1_retired_c4", retired, 1); chk("t1_busy_c4", busy, 0); chk("t1_reg_we_c4", reg_we, 0);
    tick(); tick();
    @(negedge clk); chk("t1_no_fetch_idle", imem_rd, 0); chk("t1_pc_hold", pc, 1);
    tick();
    pulse_start();
    @(negedge clk); chk("t1_second_fetch", imem_rd, 1);
    wait_idle(20, "t1");
    chk("t1_retired2", retired, 2); chk("t1_opcode2", opcode, 8'h05); chk("t1_pc2", pc, 2);

    // --- T2: memory read with MEM_LAT=2 ---
    rst = 1'b1; clear_tables(); rom[0] = 8'h07; sc_tab[8'h07] = 2'b01;
    tick(); tick(); rst = 1'b0; tick();
    pulse_start();                                   // cycle 1
    mrd_cnt = 0; mrd_first = 0; mrd_last = 0; rwe_cnt = 0; rwe_at = 0; bsy_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_rd) begin mrd_cnt++; if (mrd_first == 0) mrd_first = c; mrd_last = c; end
      if (reg_we) begin rwe_cnt++; rwe_at = c; end
      if (busy) bsy_cnt++;
      tick();
    end
    chk("t2_mrd_cycles", mrd_cnt, 3); chk("t2_mrd_first", mrd_first, 3); chk("t2_mrd_last", mrd_last, 5);
    chk("t2_reg_we_cnt", rwe_cnt, 1); chk("t2_reg_we_at", rwe_at, 6); chk("t2_instr_len", bsy_cnt, 6);

    // --- T3: illegal opcode halts; start ignored; rst clears ---
    rst = 1'b1; clear_tables(); rom[0] = 8'h25;
    tick(); tick(); rst = 1'b0; tick();
    pulse_start();
    wr_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); if (reg_we || mem_we || mem_rd) wr_cnt++; tick();
    end
    chk("t3_halted", halted, 1); chk("t3_illegal", illegal, 1); chk("t3_no_writes", wr_cnt, 0);
    pulse_start();
    n = 0;
    for (int c = 0; c < 5; c++) begin @(negedge clk); if (imem_rd || busy) n++; tick(); end
    chk("t3_start_ignored", n, 0); chk("t3_still_halted", halted, 1); chk("t3_pc", pc, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk); chk("t3_rst_illegal", illegal, 0); chk("t3_rst_halted", halted, 0);

    // --- T4: pc wrap after 256 instructions ---
    rst = 1'b1; clear_tables(); step_mode = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 31));
    tick(); tick(); rst = 1'b0; tick();
    pulse_start();
    n = 0;
    do begin @(negedge clk); if (retired != 16'd255) tick(); n++; end while (retired != 16'd255 && n < 1000);
    chk("t4_ret255", retired, 255); chk("t4_pc_ff", pc, 8'hff); chk("t4_addr_ff", imem_addr, 8'hff);
    n = 0;
    do begin tick(); @(negedge clk); n++; end while (retired != 16'd256 && n < 10);
    chk("t4_pc_wrap", pc, 8'h00); chk("t4_ret256", retired, 256);
    n = 0;
    do begin tick(); @(negedge clk); n++; end while (retired != 16'd257 && n < 10);
    chk("t4_continue_op", opcode, rom[0]); chk("t4_continue_pc", pc, 1);
    step_mode = 1'b1;
    wait_idle(20, "t4");

    // --- T5: reset during MEM_WAIT ---
    rst = 1'b1; clear_tables(); rom[0] = 8'h03; rom[1] = 8'h07; sc_tab[8'h07] = 2'b01; step_mode = 1'b0;
    tick(); tick(); rst = 1'b0; tick();
    pulse_start();                                   // cycle 1
    repeat (6) tick();                               // cycle 7: first MEM_WAIT
    @(negedge clk); chk("t5_in_wait", mem_rd, 1); chk("t5_ret_before", retired, 1);
    tick(); rst = 1'b1;                              // cycle 8: reset lands
    @(negedge clk); chk("t5_rst_cycle_mrd", mem_rd, 0);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("t5_after_busy", busy, 0); chk("t5_after_mrd", mem_rd, 0);
    chk("t5_after_pc", pc, 0); chk("t5_after_ret", retired, 0);
    tick();

    // --- T6: randomized programs, random start/step/reset ---
    for (int round = 0; round < 4; round++) begin
      rst = 1'b1; start = 1'b0;
      for (int i = 0; i < 256; i++) begin
        r = $urandom_range(0, 31);
        sc_tab[i] = (r < 14) ? 2'b00 : (r < 23) ? 2'b01 : (r < 31) ? 2'b10 : 2'b11;
        rom[i] = ($urandom_range(0, 99) < 3) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
      end
      tick(); tick(); rst = 1'b0;
      for (int c = 0; c < 1500; c++) begin
        start     = ($urandom_range(0, 7) == 0);
        step_mode = ($urandom_range(0, 3) == 0);
        rst       = ($urandom_range(0, 299) == 0);
        tick();
      end
      rst = 1'b0; start = 1'b0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/execute state machine that sequences the 8-bit processor datapath.
- Fetches opcodes from instruction ROM into an instruction register and presents the opcode to the combinational instruction decoder.
- Uses the decoder's 2-bit state_control to choose single-cycle execute, memory-read wait, memory write or halt.
- Gates every register-bank and memory write strobe so that architectural state changes only in well-defined cycles.

Parameters:
- PC_W, 8, program counter and instruction-address width.
- MEM_LAT, 2, data-memory read latency in cycles; legal range 1..15.
- LAST_OPCODE, 8'h1f, highest legal opcode; any greater opcode is illegal.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; leaves IDLE.
- step_mode  input  1  1 = return to IDLE after each retired instruction.
- imem_data  input  8  ROM read data, valid the cycle after imem_rd.
- state_control  input  2  from decoder: 00 exec, 01 mem read, 10 mem write, 11 halt.
- imem_addr  output  PC_W  ROM address; equals pc.
- imem_rd  output  1  ROM read strobe.
- opcode  output  8  instruction register contents, fed to decoder.
- reg_we  output  1  enable for the register bank's destination_reg_flag write.
- mem_rd  output  1  data-memory read strobe.
- mem_we  output  1  data-memory write strobe (qualifies decoder write).
- pc  output  PC_W  program counter.
- busy  output  1  high in any state except IDLE and HALT.
- halted  output  1  high in HALT.
- illegal  output  1  sticky; set when the halt was caused by opcode > LAST_OPCODE.
- retired  output  16  count of retired instructions; saturates at 16'hffff.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, pc=0, opcode=8'h00, retired=0, illegal=0. All strobes 0; busy=0, halted=0. Reset overrides every state, including mid-MEM_WAIT; no strobe is asserted in the reset cycle or the cycle after.
- States: IDLE, FETCH, LOAD_IR, EXEC, MEM_WAIT, WRITEBACK, HALT.
- IDLE: start=1 -> FETCH. Otherwise hold.
- FETCH: imem_rd=1, imem_addr=pc. Next state LOAD_IR.
- LOAD_IR: opcode <= imem_data; pc <= pc+1, wrapping modulo 2^PC_W. Next state EXEC.
- EXEC: decoder outputs are settled combinationally from opcode; the controller samples state_control.
  - opcode > LAST_OPCODE: illegal <= 1 -> HALT. Legality is checked before state_control is considered.
  - 00: reg_we=1 this cycle; retire.
  - 01: mem_rd=1; load wait counter with MEM_LAT-1 -> MEM_WAIT.
  - 10: mem_we=1 for exactly this cycle; retire.
  - 11: -> HALT. Halt is not counted as retired.
- MEM_WAIT: mem_rd held at 1. Counter decrements each cycle; at 0 -> WRITEBACK. With MEM_LAT=1, exactly one MEM_WAIT cycle.
- WRITEBACK: reg_we=1 (captures memory data); retire.
- Retire: retired increments, saturating at 16'hffff. Next state is FETCH if step_mode=0, IDLE if step_mode=1; step_mode is sampled in the retire cycle.
- HALT: absorbing; start is ignored. Only rst exits.
- Latency:
  - exec/store instruction = 3 cycles (FETCH, LOAD_IR, EXEC).
  - load = 4 + MEM_LAT cycles.
  - start in IDLE -> imem_rd on the next cycle.
- Mutual exclusion: at most one of reg_we, mem_we, mem_rd, imem_rd is high in any cycle.
- start asserted while busy is ignored.

Decomposition:
- Package seq_pkg:
  - state enumeration (3-bit encoding);
  - state_control codes SC_EXEC=2'b00, SC_MRD=2'b01, SC_MWR=2'b10, SC_HALT=2'b11;
  - default LAST_OPCODE.
- Sub-module wait_counter: 4-bit load/decrement counter with done flag, used for MEM_WAIT.
- The FSM, pc, IR and retire counter stay in instr_sequencer.

Test Plan:
- Reset then start; ROM[0]=8'h03 (move), state_control=00: imem_rd at cycle 1, opcode=8'h03 at cycle 3, reg_we=1 for one cycle, pc=1, retired=1.
- ROM[0] with state_control=01, MEM_LAT=2: mem_rd high for 3 consecutive cycles, then one reg_we cycle; instruction takes 6 cycles.
- ROM[0]=8'h25: illegal=1, halted=1, no reg_we/mem_we ever. A later start has no effect; rst clears both flags.
- step_mode=1 with two exec instructions: IDLE after the first retire; second fetch occurs only after the next start pulse; retired=2.
- PC_W=8, pc preset to 8'hff by running 255 exec instructions: after the next fetch pc=8'h00 and execution continues.
- rst asserted during MEM_WAIT: next cycle state=IDLE, mem_rd=0, pc=0, retired=0.
